// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame configuration writer: FSM states, header sync byte and field positions.
// FRAME_CFG_CHECKSUM_EN adds the CHECK state used for the trailing XOR checksum word.
package frame_cfg_pkg;

  localparam int unsigned WordW    = 32;
  localparam int unsigned FieldW   = 8;
  localparam logic [7:0]  SyncByte = 8'hFA;

  localparam int unsigned SyncMsb  = 31;
  localparam int unsigned SyncLsb  = 24;
  localparam int unsigned ColMsb   = 23;
  localparam int unsigned ColLsb   = 16;
  localparam int unsigned FrameMsb = 15;
  localparam int unsigned FrameLsb = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
`ifdef FRAME_CFG_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_STROBE,
    ST_GAP
  } state_e;

endpackage

// File: rtl/frame_cfg_strobe_dec.sv
// Column/frame one-hot strobe decoder; valid_c is low when either index is out of range.
module frame_cfg_strobe_dec
  import frame_cfg_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumColumns      = 8
) (
  input  logic [FieldW-1:0]                     col,
  input  logic [FieldW-1:0]                     frame,
  output logic [NumColumns*MaxFramesPerCol-1:0] onehot_c,
  output logic                                  valid_c
);

  localparam int unsigned NumStrobes = NumColumns * MaxFramesPerCol;

  logic [31:0] idx_c;

  always_comb begin
    valid_c  = (32'(col) < NumColumns) && (32'(frame) < MaxFramesPerCol);
    idx_c    = 32'(col) * 32'(MaxFramesPerCol) + 32'(frame);
    onehot_c = '0;
    for (int unsigned i = 0; i < NumStrobes; i++) begin
      onehot_c[i] = valid_c && (idx_c == 32'(i));
    end
  end

endmodule

// File: rtl/frame_cfg_writer.sv
// Streams a header plus NumRows row words into FrameData, then pulses one FrameStrobe bit.
// With FRAME_CFG_CHECKSUM_EN a trailing XOR checksum word gates the strobe.
module frame_cfg_writer
  import frame_cfg_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned NumColumns      = 8
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [31:0]                           s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                                  err_clr,
  output logic                                  err,
  output logic                                  busy,
  output logic [15:0]                           frames_done
);

  localparam int unsigned DataW   = NumRows * FrameBitsPerRow;
  localparam int unsigned StrobeW = NumColumns * MaxFramesPerCol;
  localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  state_e              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [FieldW-1:0]   col_q, col_d;
  logic [FieldW-1:0]   frm_q, frm_d;
  logic [DataW-1:0]    frame_data_q, frame_data_d;
  logic [StrobeW-1:0]  strobe_q, strobe_d;
  logic                err_q, err_d;
  logic [15:0]         frames_done_q, frames_done_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;

  logic                accept_c;
  logic                sync_ok_c;
  logic                last_row_c;
  logic                dec_valid_c;
  logic [StrobeW-1:0]  dec_onehot_c;

`ifdef FRAME_CFG_CHECKSUM_EN
  logic [WordW-1:0]    csum_q, csum_d;
  logic                csum_ok_c;
  assign csum_ok_c = (s_data == csum_q);
`else
  logic                unused_c;
  assign unused_c = ^s_data[FrameLsb-1:0];
`endif

  assign accept_c   = s_valid && s_ready_q;
  assign sync_ok_c  = (s_data[SyncMsb:SyncLsb] == SyncByte);
  assign last_row_c = (row_q == LastRow);

  frame_cfg_strobe_dec #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumColumns      (NumColumns)
  ) u_strobe_dec (
    .col      (col_q),
    .frame    (frm_q),
    .onehot_c (dec_onehot_c),
    .valid_c  (dec_valid_c)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Out-of-range targets and checksum mismatches skip STROBE and go straight to GAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c && sync_ok_c) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept_c && last_row_c) begin
`ifdef FRAME_CFG_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = dec_valid_c ? ST_STROBE : ST_GAP;
`endif
        end
      end
`ifdef FRAME_CFG_CHECKSUM_EN
      ST_CHECK:  if (accept_c) state_d = (csum_ok_c && dec_valid_c) ? ST_STROBE : ST_GAP;
`endif
      ST_STROBE: state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_d         = row_q;
    col_d         = col_q;
    frm_d         = frm_q;
    frame_data_d  = frame_data_q;
    strobe_d      = '0;
    err_d         = err_q && !err_clr;
    frames_done_d = frames_done_q;
    s_ready_d     = !((state_d == ST_STROBE) || (state_d == ST_GAP));
    busy_d        = (state_d != ST_IDLE);
`ifdef FRAME_CFG_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    if ((state_q == ST_IDLE) && accept_c) begin
      if (sync_ok_c) begin
        col_d = s_data[ColMsb:ColLsb];
        frm_d = s_data[FrameMsb:FrameLsb];
        row_d = '0;
`ifdef FRAME_CFG_CHECKSUM_EN
        csum_d = s_data;
`endif
      end else begin
        err_d = 1'b1;
      end
    end

    if ((state_q == ST_LOAD) && accept_c) begin
      for (int unsigned r = 0; r < NumRows; r++) begin
        if (row_q == RowW'(r)) begin
          frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = FrameBitsPerRow'(s_data);
        end
      end
      row_d = row_q + RowW'(1);
`ifdef FRAME_CFG_CHECKSUM_EN
      csum_d = csum_q ^ s_data;
`endif
    end

    // Strobe and count are registered on the same edge that enters STROBE.
    if ((state_d == ST_STROBE) && (state_q != ST_STROBE)) begin
      strobe_d      = dec_onehot_c;
      frames_done_d = frames_done_q + 16'd1;
    end

    if ((state_d == ST_GAP) && (state_q != ST_STROBE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_q         <= '0;
      col_q         <= '0;
      frm_q         <= '0;
      frame_data_q  <= '0;
      strobe_q      <= '0;
      err_q         <= 1'b0;
      frames_done_q <= '0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
`ifdef FRAME_CFG_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      frm_q         <= frm_d;
      frame_data_q  <= frame_data_d;
      strobe_q      <= strobe_d;
      err_q         <= err_d;
      frames_done_q <= frames_done_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
`ifdef FRAME_CFG_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign s_ready     = s_ready_q;
  assign FrameData   = frame_data_q;
  assign FrameStrobe = strobe_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign frames_done = frames_done_q;

endmodule
